// File: rtl/julia_writeback.sv
// ----------------------------------------------------------------------------
// julia_writeback
//
// Purpose:
//   Consumer of the Julia worker search/select stage. When the search stage
//   reports a found worker, the pixel address and colour are latched and the
//   colour word is written to the frame buffer over an Avalon-MM-style master
//   with waitrequest. Once the write is accepted, the serviced worker gets a
//   one-hot ack pulse and the search stage gets a release pulse. A SETTLE
//   cycle follows, so the worker can drop its done flag and the search mask
//   can shift before the next capture. Written pixels are counted, and
//   frame_done is raised when the count reaches NUM_PIXELS.
//
// Ports:
//   clk, rst        - clock; asynchronous active-high reset
//   found           - search stage has a valid selection this cycle
//   sel_address     - pixel index of the selected worker
//   sel_data        - colour word of the selected worker
//   mask, done      - search mask and worker done flags (grant = mask & done)
//   release_search  - one-cycle pulse that advances the search mask
//   worker_ack      - one-hot, one-cycle ack to the serviced worker
//   mem_address     - frame-buffer byte address (FB_BASE + 4*pixel)
//   mem_writedata   - colour word
//   mem_write       - write request, held until accepted
//   mem_waitrequest - slave stall
//   frame_clear     - synchronous clear of pixel_count and frame_done
//   pixel_count     - pixels written this frame (saturating)
//   frame_done      - sticky frame-complete flag
//   oob_count       - dropped out-of-range pixels (only with the macro below)
//
// Configuration:
//   JULIA_WRITEBACK_BOUNDS_EN - when defined, a captured pixel index
//   >= NUM_PIXELS skips the write (IDLE->ACK), is not counted as written,
//   and is counted in oob_count instead.
// ----------------------------------------------------------------------------
module julia_writeback #(
    parameter int          NUM_JULIA  = 8,
    parameter logic [31:0] FB_BASE    = 32'h0000_0000,
    parameter int          NUM_PIXELS = 307200,
    parameter int          CNT_W      = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 found,
    input  logic [31:0]          sel_address,
    input  logic [31:0]          sel_data,
    input  logic [NUM_JULIA-1:0] mask,
    input  logic [NUM_JULIA-1:0] done,
    output logic                 release_search,
    output logic [NUM_JULIA-1:0] worker_ack,
    output logic [31:0]          mem_address,
    output logic [31:0]          mem_writedata,
    output logic                 mem_write,
    input  logic                 mem_waitrequest,
    input  logic                 frame_clear,
    output logic [CNT_W-1:0]     pixel_count,
    output logic                 frame_done
`ifdef JULIA_WRITEBACK_BOUNDS_EN
    ,
    output logic [15:0]          oob_count
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        ACK    = 2'd2,
        SETTLE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX      = '1;
    localparam logic [CNT_W-1:0] FRAME_TARGET = CNT_W'(NUM_PIXELS);

    state_t               state;
    state_t               next_state;
    logic [NUM_JULIA-1:0] grant;
    logic [CNT_W-1:0]     cnt_next;
    logic                 capture;
    logic                 count_pixel;

`ifdef JULIA_WRITEBACK_BOUNDS_EN
    localparam logic [31:0] PIXEL_LIMIT = 32'(NUM_PIXELS);
    logic addr_oob;
    logic skip_write;   // latched at capture: this transaction was dropped
    assign addr_oob    = (sel_address >= PIXEL_LIMIT);
    assign count_pixel = (state == ACK) && !skip_write;
`else
    assign count_pixel = (state == ACK);
`endif

    assign capture  = (state == IDLE) && found;
    assign cnt_next = (pixel_count == CNT_MAX) ? pixel_count : pixel_count + 1'b1;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and decoded outputs. Handshake outputs decode the state
    // directly, so an async reset drops mem_write in the same instant.
    // ------------------------------------------------------------------------
    // NOTE: every output of this block gets a default first; a path that
    // skips an assignment would otherwise infer a latch.
    always_comb begin
        next_state     = state;
        mem_write      = 1'b0;
        release_search = 1'b0;
        worker_ack     = '0;
        unique case (state)
            IDLE: begin
                if (found) begin
`ifdef JULIA_WRITEBACK_BOUNDS_EN
                    next_state = addr_oob ? ACK : WRITE;
`else
                    next_state = WRITE;
`endif
                end
            end
            WRITE: begin
                mem_write = 1'b1;
                if (!mem_waitrequest) begin
                    next_state = ACK;
                end
            end
            ACK: begin
                worker_ack     = grant;
                release_search = 1'b1;
                next_state     = SETTLE;
            end
            SETTLE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Transaction latch: address, data and grant are captured once in IDLE
    // and held stable for the whole WRITE/ACK sequence.
    // ------------------------------------------------------------------------
    // NOTE: these are plain registers, not a memory array, so resetting them
    // is cheap and guarantees mem_address/mem_writedata read 0 after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_address   <= '0;
            mem_writedata <= '0;
            grant         <= '0;
`ifdef JULIA_WRITEBACK_BOUNDS_EN
            skip_write    <= 1'b0;
`endif
        end else if (capture) begin
            mem_address   <= FB_BASE + (sel_address << 2);
            mem_writedata <= sel_data;
            // mask & done is one-hot when the search stage is consistent; an
            // all-zero grant still completes the write and release.
            grant         <= mask & done;
`ifdef JULIA_WRITEBACK_BOUNDS_EN
            skip_write    <= addr_oob;
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Frame accounting. frame_clear has priority over an ACK increment and
    // never disturbs the FSM or an in-flight write.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_count <= '0;
            frame_done  <= 1'b0;
        end else if (frame_clear) begin
            pixel_count <= '0;
            frame_done  <= 1'b0;
        end else if (count_pixel) begin
            pixel_count <= cnt_next;
            if (cnt_next == FRAME_TARGET) begin
                frame_done <= 1'b1;
            end
        end
    end

`ifdef JULIA_WRITEBACK_BOUNDS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oob_count <= '0;
        end else if (frame_clear) begin
            oob_count <= '0;
        end else if ((state == ACK) && skip_write && (oob_count != 16'hFFFF)) begin
            oob_count <= oob_count + 16'd1;
        end
    end
`endif

endmodule
